spi_slave_interface: RTL and testbench

- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) that forms the far end of the team's SPI initiator link.
- Oversamples sclk, scsn and mosi in the local clk domain.
- Deserialises mosi into an RX FIFO write port and serialises TX FIFO data onto miso.
- Used for loopback benches and for FPGA-side register/bridge targets driven by the JTAG-to-SPI path.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_interface.sv | 149 ++++++++++++++
 tb/tb_spi_slave_interface.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI responder.
// FSM state encoding and frame-length width.
package spi_pkg;

  localparam int SPI_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_END
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a delay flop.
// Produces level, rise and fall for one async input.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  // Shift the async input through the chain, then delay once for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      dly   <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/spi_slave_interface.sv
// SPI mode-0 responder, MSB first.
// Oversampled in clk; RX/TX FIFO ports on the local side.
module spi_slave_interface
  import spi_pkg::*;
#(
  parameter int DATA        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 scsn,
  input  logic                 mosi,
  output logic                 miso,
  output logic [DATA-1:0]      wdata,
  output logic                 wr,
  input  logic                 full,
  input  logic [DATA-1:0]      rdata,
  output logic                 rd,
  input  logic                 empty,
  output logic                 busy,
  output logic [SPI_LEN_W-1:0] frame_len,
  output logic                 overrun,
  output logic                 underrun,
  input  logic                 clr_flags
);

  localparam int            CW   = $clog2(DATA);
  localparam logic [CW-1:0] LAST = CW'(DATA - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_slv_state_t       state, state_nxt;
  logic [DATA-1:0]      tx_shift, rx_shift;
  logic [CW-1:0]        bit_cnt;
  logic [SPI_LEN_W-1:0] word_cnt;
  logic                 reload_pending;
  logic                 shifting, load_now, rx_last;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scsn (
    .clk(clk), .rst(rst), .din(scsn),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused),
    .fall(mosi_fall_unused)
  );

  // A deselect edge outranks any sclk edge in the same cycle
  assign shifting = (state == ST_SHIFT) & ~cs_rise;
  assign load_now = (state == ST_LOAD) |
                    (shifting & sclk_fall & reload_pending);
  assign rx_last  = shifting & sclk_rise & (bit_cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (cs_fall) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = cs_rise ? ST_END : ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_nxt = ST_END;
      ST_END:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FIFO pop and serial output follow the current state directly
  always_comb begin
    rd   = load_now & ~empty;
    miso = (state == ST_SHIFT) ? tx_shift[DATA-1] : 1'b0;
  end

  // Shift registers, counters, strobes and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift       <= '0;
      rx_shift       <= '0;
      bit_cnt        <= '0;
      word_cnt       <= '0;
      reload_pending <= 1'b0;
      wdata          <= '0;
      wr             <= 1'b0;
      busy           <= 1'b0;
      frame_len      <= '0;
      overrun        <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      wr <= 1'b0;

      if (load_now) begin
        tx_shift       <= empty ? '0 : rdata;
        reload_pending <= 1'b0;
      end else if (shifting & sclk_fall) begin
        tx_shift <= {tx_shift[DATA-2:0], 1'b0};
      end

      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            busy           <= 1'b1;
            bit_cnt        <= '0;
            word_cnt       <= '0;
            reload_pending <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (shifting & sclk_rise) begin
            rx_shift <= {rx_shift[DATA-2:0], mosi_s};
            if (bit_cnt == LAST) begin
              wdata          <= {rx_shift[DATA-2:0], mosi_s};
              wr             <= ~full;
              bit_cnt        <= '0;
              reload_pending <= 1'b1;
              if (~&word_cnt)
                word_cnt <= word_cnt + SPI_LEN_W'(1);
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        ST_END: begin
          frame_len <= word_cnt;
          busy      <= 1'b0;
          bit_cnt   <= '0;
        end
        default: ;
      endcase

      overrun  <= (rx_last & full) | (overrun & ~clr_flags);
      underrun <= (load_now & empty) | (underrun & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_spi_slave_interface.sv
// Directed bench for spi_slave_interface.
// Drives mode-0 frames, models the TX FIFO, logs RX writes.
module tb_spi_slave_interface;

  localparam int SS   = 2;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst, sclk, scsn, mosi, miso;
  logic [7:0]  wdata, rdata;
  logic        wr, full, rd, empty, busy;
  logic [15:0] frame_len;
  logic        overrun, underrun, clr_flags;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_mem [0:15];
  logic [3:0] tx_wr = 4'd0;
  logic [3:0] tx_rd = 4'd0;
  logic       rd_seen = 1'b0;
  logic [7:0] rx_log [0:31];
  int         rx_n   = 0;
  int         rd_n   = 0;

  logic [7:0] mosi_words [0:3];
  logic [7:0] miso_got   [0:3];
  int         full_word = 99;

  assign empty = (tx_rd == tx_wr);
  assign rdata = tx_mem[tx_rd];

  always #5 clk = ~clk;

  spi_slave_interface #(.DATA(8), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .scsn(scsn),
    .mosi(mosi), .miso(miso), .wdata(wdata), .wr(wr),
    .full(full), .rdata(rdata), .rd(rd), .empty(empty),
    .busy(busy), .frame_len(frame_len),
    .overrun(overrun), .underrun(underrun),
    .clr_flags(clr_flags)
  );

  always @(negedge clk) begin
    rd_seen = rd;
    if (rd) rd_n++;
    if (wr) begin
      rx_log[rx_n[4:0]] = wdata;
      rx_n++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_seen && tx_rd != tx_wr) tx_rd = tx_rd + 4'd1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] v);
    tx_mem[tx_wr] = v;
    tx_wr = tx_wr + 4'd1;
  endtask

  task automatic spi_frame(input int n, input int last_bits);
    int nb;
    logic [7:0] w8;
    @(negedge clk);
    scsn = 1'b0;
    sclk = 1'b0;
    for (int w = 0; w < n; w++) begin
      nb = (w == n - 1) ? last_bits : 8;
      w8 = mosi_words[w];
      full = (w >= full_word);
      miso_got[w] = 8'h00;
      for (int b = 0; b < nb; b++) begin
        mosi = w8[7-b];
        repeat (HALF) @(negedge clk);
        miso_got[w][7-b] = miso;
        if (w == 0 && b == 0) check("busy_in_frame", 32'(busy), 32'd1);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        if (w == n - 1 && b == nb - 1) scsn = 1'b1;
      end
    end
    full = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  int rx0, rd0;

  initial begin
    rst = 1'b1; sclk = 1'b0; scsn = 1'b1; mosi = 1'b0;
    full = 1'b0; clr_flags = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_len", 32'(frame_len), 32'd0);
    check("rst_flags", 32'({overrun, underrun}), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single word
    rx0 = rx_n; rd0 = rd_n;
    push_tx(8'hA5);
    mosi_words[0] = 8'h3C;
    spi_frame(1, 8);
    repeat (8) @(negedge clk);
    check("s_wr_cnt", 32'(rx_n - rx0), 32'd1);
    check("s_wdata", 32'(rx_log[rx0[4:0]]), 32'h3C);
    check("s_rd_cnt", 32'(rd_n - rd0), 32'd1);
    check("s_miso", 32'(miso_got[0]), 32'hA5);
    check("s_len", 32'(frame_len), 32'd1);
    check("s_flags", 32'({overrun, underrun}), 32'd0);
    check("s_busy", 32'(busy), 32'd0);

    // back-to-back
    rx0 = rx_n; rd0 = rd_n;
    push_tx(8'h01); push_tx(8'h80); push_tx(8'hFF);
    mosi_words[0] = 8'h11;
    mosi_words[1] = 8'h22;
    mosi_words[2] = 8'h33;
    spi_frame(3, 8);
    repeat (8) @(negedge clk);
    check("b_wr_cnt", 32'(rx_n - rx0), 32'd3);
    check("b_wd0", 32'(rx_log[rx0[4:0]]), 32'h11);
    check("b_wd1", 32'(rx_log[5'(rx0 + 1)]), 32'h22);
    check("b_wd2", 32'(rx_log[5'(rx0 + 2)]), 32'h33);
    check("b_rd_cnt", 32'(rd_n - rd0), 32'd3);
    check("b_miso0", 32'(miso_got[0]), 32'h01);
    check("b_miso1", 32'(miso_got[1]), 32'h80);
    check("b_miso2", 32'(miso_got[2]), 32'hFF);
    check("b_len", 32'(frame_len), 32'd3);
    check("b_flags", 32'({overrun, underrun}), 32'd0);

    // empty TX
    rx0 = rx_n; rd0 = rd_n;
    mosi_words[0] = 8'h55;
    spi_frame(1, 8);
    repeat (8) @(negedge clk);
    check("e_miso", 32'(miso_got[0]), 32'h00);
    check("e_underrun", 32'(underrun), 32'd1);
    check("e_overrun", 32'(overrun), 32'd0);
    check("e_rd_cnt", 32'(rd_n - rd0), 32'd0);
    check("e_wr_cnt", 32'(rx_n - rx0), 32'd1);
    check("e_wdata", 32'(rx_log[rx0[4:0]]), 32'h55);
    pulse_clr();
    check("e_clr", 32'(underrun), 32'd0);

    // full RX on second word
    rx0 = rx_n;
    push_tx(8'h12); push_tx(8'h34);
    mosi_words[0] = 8'hAA;
    mosi_words[1] = 8'hBB;
    full_word = 1;
    spi_frame(2, 8);
    full_word = 99;
    repeat (8) @(negedge clk);
    check("f_wr_cnt", 32'(rx_n - rx0), 32'd1);
    check("f_wdata", 32'(rx_log[rx0[4:0]]), 32'hAA);
    check("f_overrun", 32'(overrun), 32'd1);
    check("f_len", 32'(frame_len), 32'd2);
    pulse_clr();
    check("f_clr", 32'(overrun), 32'd0);

    // abort after 5 bits of second word
    rx0 = rx_n;
    push_tx(8'h5A); push_tx(8'h6B);
    mosi_words[0] = 8'h77;
    mosi_words[1] = 8'h88;
    spi_frame(2, 5);
    repeat (2 + SS) @(posedge clk);
    #1;
    check("a_busy", 32'(busy), 32'd0);
    check("a_len", 32'(frame_len), 32'd1);
    repeat (8) @(negedge clk);
    check("a_wr_cnt", 32'(rx_n - rx0), 32'd1);
    check("a_wdata", 32'(rx_log[rx0[4:0]]), 32'h77);
    check("a_overrun", 32'(overrun), 32'd0);

    // reset mid-frame after 3 bits
    @(negedge clk);
    scsn = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mosi = b[0];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("r_miso", 32'(miso), 32'd0);
    check("r_wdata", 32'(wdata), 32'd0);
    check("r_wr_rd", 32'({wr, rd}), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_len", 32'(frame_len), 32'd0);
    check("r_flags", 32'({overrun, underrun}), 32'd0);
    @(negedge clk);
    scsn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    rx0 = rx_n;
    push_tx(8'h3C);
    mosi_words[0] = 8'hC3;
    spi_frame(1, 8);
    repeat (8) @(negedge clk);
    check("r_wr_cnt", 32'(rx_n - rx0), 32'd1);
    check("r_wdata2", 32'(rx_log[rx0[4:0]]), 32'hC3);
    check("r_miso2", 32'(miso_got[0]), 32'h3C);
    check("r_len2", 32'(frame_len), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
